// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divider with IDLE/BUSY/DONE sequencer for DIV/DIVU in E.
// Optional DIV_EARLY_OUT_EN: skip BUSY when the divisor is zero or |a| < |b|.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             E_div_start,
    input  logic             E_div_signed,
    input  logic [WIDTH-1:0] E_div_a,
    input  logic [WIDTH-1:0] E_div_b,
    input  logic             pipe_adv,
    input  logic             M_except,
    output logic             E_div_stall,
    output logic [WIDTH-1:0] div_lo,
    output logic [WIDTH-1:0] div_hi,
    output logic             div_valid
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo, dvs, rem, a_raw;
    logic             neg_q, neg_r, b_zero;

    logic [WIDTH-1:0] a_mag, b_mag;
    logic             start_ok, last_step, early_out;
    logic [WIDTH:0]   rem_sh, trial;
    logic             take;
    logic [WIDTH-1:0] rem_step, quo_step, lo_fin, hi_fin;

    always_comb begin
        a_mag     = (E_div_signed && E_div_a[WIDTH-1]) ? -E_div_a : E_div_a;
        b_mag     = (E_div_signed && E_div_b[WIDTH-1]) ? -E_div_b : E_div_b;
        start_ok  = (state == IDLE) && E_div_start && !M_except;
        last_step = (state == BUSY) && (cnt == CW'(WIDTH - 1));
`ifdef DIV_EARLY_OUT_EN
        early_out = (E_div_b == '0) || (a_mag < b_mag);
`else
        early_out = 1'b0;
`endif
    end

    // One restoring step: the dividend shifts out of quo as quotient bits shift in.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        trial    = rem_sh - {1'b0, dvs};
        take     = !trial[WIDTH];
        rem_step = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step = {quo[WIDTH-2:0], take};
        lo_fin   = neg_q ? -quo_step : quo_step;
        hi_fin   = neg_r ? -rem_step : rem_step;
        if (b_zero) begin
            lo_fin = '1;
            hi_fin = a_raw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_ok) state_nxt = early_out ? DONE : BUSY;
            BUSY: if (last_step) state_nxt = DONE;
            DONE: if (pipe_adv) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (M_except) state_nxt = IDLE;
    end

    always_comb begin
        E_div_stall = 1'b0;
        if (!rst && !M_except)
            E_div_stall = ((state == IDLE) && E_div_start) || (state == BUSY);
        div_valid = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            quo    <= '0;
            dvs    <= '0;
            rem    <= '0;
            a_raw  <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            div_lo <= '0;
            div_hi <= '0;
        end else if (start_ok) begin
            cnt    <= '0;
            quo    <= a_mag;
            dvs    <= b_mag;
            rem    <= '0;
            a_raw  <= E_div_a;
            neg_q  <= E_div_signed && (E_div_a[WIDTH-1] ^ E_div_b[WIDTH-1]);
            neg_r  <= E_div_signed && E_div_a[WIDTH-1];
            b_zero <= (E_div_b == '0);
            if (early_out) begin
                div_lo <= (E_div_b == '0) ? '1 : '0;
                div_hi <= E_div_a;
            end
        end else if ((state == BUSY) && !M_except) begin
            quo <= quo_step;
            rem <= rem_step;
            cnt <= cnt + CW'(1);
            if (last_step) begin
                div_lo <= lo_fin;
                div_hi <= hi_fin;
            end
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Randomized self-checking bench for div_sequencer against an arithmetic reference model.
// Honours DIV_EARLY_OUT_EN when predicting stall length.
module tb_div_sequencer;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         E_div_start, E_div_signed, pipe_adv, M_except;
    logic [W-1:0] E_div_a, E_div_b;
    logic         E_div_stall, div_valid;
    logic [W-1:0] div_lo, div_hi;

    int n_checks = 0;
    int n_errors = 0;

    div_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .E_div_start(E_div_start), .E_div_signed(E_div_signed),
        .E_div_a(E_div_a), .E_div_b(E_div_b),
        .pipe_adv(pipe_adv), .M_except(M_except),
        .E_div_stall(E_div_stall), .div_lo(div_lo), .div_hi(div_hi),
        .div_valid(div_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: truncating division, remainder takes the dividend's sign; b==0 special case.
    task automatic ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output int stall);
        longint sa, sb, ma, mb;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
        end
        stall = W + 1;
`ifdef DIV_EARLY_OUT_EN
        if (b == 0 || ma < mb) stall = 1;
`else
        if (ma < 0) stall = 0;
`endif
    endtask

    task automatic run_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int hold);
        logic [W-1:0] q, r;
        int exp_stall, cycles;
        ref_div(sgn, a, b, q, r, exp_stall);
        @(posedge clk); #1;
        E_div_start = 1'b1; E_div_signed = sgn; E_div_a = a; E_div_b = b;
        pipe_adv = (hold == 0);
        #1;
        cycles = 0;
        while (E_div_stall && cycles < 100) begin
            cycles++;
            @(posedge clk); #1;
            E_div_a = $urandom; E_div_b = $urandom;
            #1;
        end
        check("stall_len", 64'(cycles), 64'(exp_stall));
        check("valid_done", 64'(div_valid), 64'd1);
        check("lo", 64'(div_lo), 64'(q));
        check("hi", 64'(div_hi), 64'(r));
        repeat (hold) begin
            @(posedge clk); #2;
            check("hold_valid", 64'(div_valid), 64'd1);
            check("hold_stall", 64'(E_div_stall), 64'd0);
            check("hold_lo", 64'(div_lo), 64'(q));
            check("hold_hi", 64'(div_hi), 64'(r));
        end
        pipe_adv = 1'b1;
        @(posedge clk); #1;
        E_div_start = 1'b0;
        #1;
        check("valid_after_adv", 64'(div_valid), 64'd0);
        check("lo_holds", 64'(div_lo), 64'(q));
    endtask

    task automatic run_flush(input logic [W-1:0] a, input logic [W-1:0] b, input int busy_cyc);
        logic [W-1:0] old_lo, old_hi;
        old_lo = div_lo; old_hi = div_hi;
        @(posedge clk); #1;
        E_div_start = 1'b1; E_div_signed = 1'b0; E_div_a = a; E_div_b = b; pipe_adv = 1'b1;
        repeat (busy_cyc) @(posedge clk);
        #1; M_except = 1'b1; #1;
        check("flush_stall", 64'(E_div_stall), 64'd0);
        @(posedge clk); #1;
        M_except = 1'b0; E_div_start = 1'b0; #1;
        check("flush_stall_after", 64'(E_div_stall), 64'd0);
        repeat (40) begin
            @(posedge clk); #2;
            check("flush_valid", 64'(div_valid), 64'd0);
        end
        check("flush_lo", 64'(div_lo), 64'(old_lo));
        check("flush_hi", 64'(div_hi), 64'(old_hi));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst = 1'b1; E_div_start = 1'b1; E_div_signed = 1'b0;
        E_div_a = 32'd9; E_div_b = 32'd3; pipe_adv = 1'b1; M_except = 1'b0;
        @(posedge clk); #2;
        check("rst_stall", 64'(E_div_stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; E_div_start = 1'b0; #1;
        check("rst_lo", 64'(div_lo), 64'd0);
        check("rst_hi", 64'(div_hi), 64'd0);
        check("rst_valid", 64'(div_valid), 64'd0);

        run_div(1'b0, 32'd100, 32'd7, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 0);
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        run_div(1'b0, 32'd5, 32'd0, 0);
        run_div(1'b1, 32'hFFFF_FFFB, 32'd0, 0);
        run_div(1'b0, 32'hFFFF_FFFF, 32'd1, 3);
        run_div(1'b0, 32'd3, 32'd10, 0);
        run_div(1'b1, 32'hFFFF_FFFD, 32'd10, 0);
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, 2);
        run_flush(32'd1234, 32'd5, 10);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(0, 15));
                1: rb = $urandom;
                2: rb = ra >> $urandom_range(1, 31);
                default: rb = -32'($urandom_range(1, 9));
            endcase
            run_div(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 2));
        end

        @(posedge clk); #1;
        E_div_start = 1'b1; E_div_signed = 1'b0; E_div_a = 32'd77; E_div_b = 32'd3;
        repeat (5) @(posedge clk);
        #1; rst = 1'b1; #1;
        check("rst_mid_stall", 64'(E_div_stall), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; E_div_start = 1'b0; #1;
        check("rst_mid_lo", 64'(div_lo), 64'd0);
        check("rst_mid_hi", 64'(div_hi), 64'd0);
        check("rst_mid_valid", 64'(div_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
